// File: rtl/dbg_capture_pkg.sv
// Shared definitions for the debug capture engine: FSM state encoding and
// a constant width helper used to size parameters.
package dbg_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Ceiling log2; returns 0 for v <= 1. Callers apply their own minimum.
  function automatic int clog2(input int unsigned v);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > (32'd1 << i)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dbg_capture_sdpram.sv
// Simple dual-port RAM, one write port and one registered read port on a
// single clock. Behavioural model of the memory-compiler macro; slp_i
// gates both ports so the macro's sleep pin maps straight across.
module dbg_capture_sdpram #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  slp_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array write and registered read; no reset on storage, like the macro.
  always_ff @(posedge clk) begin
    if (we_i && !slp_i) mem[waddr_i] <= wdata_i;
    if (re_i && !slp_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbg_capture_ctrl.sv
// Debug capture engine: circular pre-trigger window, post-trigger fill,
// trigger-relative readout. Optional write decimation is compiled in with
// the DBG_CAPTURE_DECIM_EN macro (adds the decim port).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no capture in progress, waiting for arm
// ST_PRE   | filling the first pre_len samples, trigger ignored
// ST_ARMED | circular writes, waiting for a qualified trigger
// ST_POST  | filling the post-trigger window
// ST_DONE  | capture complete, writes inhibited, readout enabled
module dbg_capture_ctrl
  import dbg_capture_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = clog2(RAM_DEPTH),
  parameter int CH_W       = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arm,
  input  logic                         abort,
  input  logic [CH_W-1:0]              ch_sel,
  input  logic [ADDR_WIDTH-1:0]        pre_len,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic                         din_vld,
  input  logic                         trig,
`ifdef DBG_CAPTURE_DECIM_EN
  input  logic [7:0]                   decim,
`endif
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_vld,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        trig_ptr
);

  state_e                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d, ch_in;
  logic [ADDR_WIDTH-1:0] pre_len_q, pre_len_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d, fill_inc;
  logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d, post_init;
  logic [ADDR_WIDTH-1:0] start_ptr_q, start_ptr_d;
  logic [ADDR_WIDTH-1:0] trig_ptr_q, trig_ptr_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  rd_vld_q, rd_ram_q;
  logic                  accept_arm, keep, sample_wr, ram_we, ram_re;
  logic [DATA_WIDTH-1:0] sample, ram_rdata;

  assign accept_arm = arm && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign ch_in      = (int'(ch_sel) < NUM_CH) ? ch_sel : '0;
  assign fill_inc   = fill_cnt_q + 1'b1;
  // RAM_DEPTH - pre_len - 1 is the bitwise complement at ADDR_WIDTH bits.
  assign post_init  = ~pre_len_q;

`ifdef DBG_CAPTURE_DECIM_EN
  logic [7:0] decim_q, decim_d, dcnt_q, dcnt_d;

  // Modulo-(decim+1) phase counter; only phase 0 samples are stored.
  always_comb begin
    decim_d = decim_q;
    dcnt_d  = dcnt_q;
    if (accept_arm) begin
      decim_d = decim;
      dcnt_d  = '0;
    end else if (din_vld) begin
      dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
    end
  end

  // Decimation state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q <= '0;
      dcnt_q  <= '0;
    end else begin
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign keep = (dcnt_q == 8'd0);
`else
  assign keep = 1'b1;
`endif

  assign sample_wr = din_vld && keep;

  // Select the latched channel out of the packed sample bus.
  always_comb begin
    sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) sample = din[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state, pointer and write-enable logic.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pre_len_d   = pre_len_q;
    wptr_d      = wptr_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    start_ptr_d = start_ptr_q;
    trig_ptr_d  = trig_ptr_q;
    ram_we      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_arm) begin
          ch_d       = ch_in;
          pre_len_d  = pre_len;
          wptr_d     = '0;
          fill_cnt_d = '0;
          state_d    = (pre_len == '0) ? ST_ARMED : ST_PRE;
        end
      end
      ST_PRE: begin
        if (sample_wr) begin
          ram_we     = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          fill_cnt_d = fill_inc;
          if (fill_inc == pre_len_q) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (sample_wr) begin
          ram_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (trig) begin
            trig_ptr_d  = wptr_q;
            start_ptr_d = wptr_q - pre_len_q;
            post_cnt_d  = post_init;
            state_d     = (post_init == '0) ? ST_DONE : ST_POST;
          end
        end
      end
      ST_POST: begin
        if (sample_wr) begin
          ram_we     = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == ADDR_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      ram_we  = 1'b0;
    end
    busy_d = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
  end

  // FSM state and capture bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      pre_len_q   <= '0;
      wptr_q      <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      start_ptr_q <= '0;
      trig_ptr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pre_len_q   <= pre_len_d;
      wptr_q      <= wptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      start_ptr_q <= start_ptr_d;
      trig_ptr_q  <= trig_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Reads outside DONE still answer, but with zero data and no RAM access.
  assign ram_re = rd_en && (state_q == ST_DONE);

  // Readout handshake registers, aligned with the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_ram_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      rd_ram_q <= ram_re;
    end
  end

  dbg_capture_sdpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAM_DEPTH (RAM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .slp_i  (1'b0),
    .we_i   (ram_we),
    .waddr_i(wptr_q),
    .wdata_i(sample),
    .re_i   (ram_re),
    .raddr_i(start_ptr_q + rd_addr),
    .rdata_o(ram_rdata)
  );

  assign rd_data  = rd_ram_q ? ram_rdata : '0;
  assign rd_vld   = rd_vld_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign trig_ptr = trig_ptr_q;

endmodule

// File: tb/tb_dbg_capture_ctrl.sv
// Bench for dbg_capture_ctrl at RAM_DEPTH=16. Build with
// DBG_CAPTURE_DECIM_EN defined to add the decimation scenario.
module tb_dbg_capture_ctrl;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int CW     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              arm = 1'b0, abort = 1'b0, din_vld = 1'b0, trig = 1'b0, rd_en = 1'b0;
  logic [CW-1:0]     ch_sel = '0;
  logic [AW-1:0]     pre_len = '0, rd_addr = '0;
  logic [NUM_CH*DW-1:0] din = '0;
`ifdef DBG_CAPTURE_DECIM_EN
  logic [7:0]        decim = '0;
`endif
  logic [DW-1:0]     rd_data;
  logic              rd_vld, busy, done;
  logic [AW-1:0]     trig_ptr;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  dbg_capture_ctrl #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .CH_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .ch_sel(ch_sel),
    .pre_len(pre_len), .din(din), .din_vld(din_vld), .trig(trig),
`ifdef DBG_CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
    .busy(busy), .done(done), .trig_ptr(trig_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every rd_vld must match the oldest queued request.
  always @(negedge clk) begin
    if (rst_n && rd_vld) begin
      if (exp_q.size() == 0) chk("unexpected_rd_vld", 32'd1, 32'd0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic drive_sample(input int idx, input bit t);
    din_vld = 1'b1;
    trig    = t;
    for (int k = 0; k < NUM_CH; k++) din[k*DW +: DW] = 32'(k << 28) + 32'(idx);
    @(posedge clk); #1;
    din_vld = 1'b0;
    trig    = 1'b0;
  endtask

  task automatic do_arm(input int ch, input int pre);
    arm = 1'b1; ch_sel = CW'(ch); pre_len = AW'(pre);
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic read_addr(input int a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = AW'(a);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Feed consecutive samples until done rises, bounded; returns next index.
  task automatic feed_until_done(input int start, input int trig_at, input int fake,
                                 input bit gaps, output int n);
    n = start;
    while (done !== 1'b1 && n < start + 200) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
      end
      drive_sample(n, (n == trig_at) || (n == fake));
      n++;
    end
  endtask

  typedef struct {
    int ch; int pre; int trig_at; int fake; bit gaps; int dec; int exp_tp;
  } scen_t;

  scen_t tbl[$];

  initial begin
    int n, total, kk, a;
    logic [31:0] ev;

    tbl.push_back('{ch: 2, pre: 4,  trig_at: 9,  fake: 2,  gaps: 0, dec: 0, exp_tp: 9});
    tbl.push_back('{ch: 1, pre: 4,  trig_at: 40, fake: -1, gaps: 0, dec: 0, exp_tp: 8});
    tbl.push_back('{ch: 3, pre: 0,  trig_at: 0,  fake: -1, gaps: 0, dec: 0, exp_tp: 0});
    tbl.push_back('{ch: 0, pre: 15, trig_at: 15, fake: 5,  gaps: 0, dec: 0, exp_tp: 15});
    tbl.push_back('{ch: 1, pre: 7,  trig_at: 7,  fake: 3,  gaps: 1, dec: 0, exp_tp: 7});
    tbl.push_back('{ch: 3, pre: 10, trig_at: 30, fake: 8,  gaps: 1, dec: 0, exp_tp: 14});
`ifdef DBG_CAPTURE_DECIM_EN
    tbl.push_back('{ch: 0, pre: 2,  trig_at: 9,  fake: 7,  gaps: 0, dec: 2, exp_tp: 3});
`endif

    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rd_vld", 32'(rd_vld), 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_trig_ptr", 32'(trig_ptr), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[s]) begin
`ifdef DBG_CAPTURE_DECIM_EN
      decim = 8'(tbl[s].dec);
`endif
      do_arm(tbl[s].ch, tbl[s].pre);
      chk($sformatf("s%0d_busy_after_arm", s), 32'(busy), 1);
      chk($sformatf("s%0d_done_after_arm", s), 32'(done), 0);
      feed_until_done(0, tbl[s].trig_at, tbl[s].fake, tbl[s].gaps, n);
      total = tbl[s].trig_at + (DEPTH - 1 - tbl[s].pre) * (tbl[s].dec + 1) + 1;
      chk($sformatf("s%0d_done", s), 32'(done), 1);
      chk($sformatf("s%0d_samples_to_done", s), 32'(n), 32'(total));
      chk($sformatf("s%0d_busy_done", s), 32'(busy), 0);
      chk($sformatf("s%0d_trig_ptr", s), 32'(trig_ptr), 32'(tbl[s].exp_tp));
      kk = tbl[s].trig_at / (tbl[s].dec + 1);
      for (int i = 0; i < DEPTH; i++) begin
        a  = (i * 7 + s) % DEPTH;
        ev = 32'(tbl[s].ch << 28) + 32'((tbl[s].dec + 1) * (kk - tbl[s].pre + a));
        read_addr(a, ev);
      end
      drain();
    end

    // Abort during POST.
    do_arm(0, 2);
    drive_sample(0, 0); drive_sample(1, 0); drive_sample(2, 1);
    drive_sample(3, 0); drive_sample(4, 0);
    chk("post_busy", 32'(busy), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);

    // Arm and abort together stay in IDLE.
    arm = 1'b1; abort = 1'b1; ch_sel = 2'd0; pre_len = 4'd3;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("arm_abort_busy_hold", 32'(busy), 0);

    // Arm while ARMED is ignored: channel, window and pointers are kept.
    do_arm(1, 2);
    drive_sample(0, 0); drive_sample(1, 0); drive_sample(2, 0);
    arm = 1'b1; ch_sel = 2'd3; pre_len = 4'd0;
    @(posedge clk); #1;
    arm = 1'b0;
    chk("rearm_busy", 32'(busy), 1);
    feed_until_done(3, 5, -1, 0, n);
    chk("rearm_samples_to_done", 32'(n), 32'd19);
    chk("rearm_trig_ptr", 32'(trig_ptr), 32'd5);
    read_addr(0, 32'h1000_0003);
    read_addr(2, 32'h1000_0005);
    read_addr(15, 32'h1000_0012);
    drain();

    // Asynchronous reset in the middle of POST.
    do_arm(2, 2);
    drive_sample(0, 0); drive_sample(1, 0); drive_sample(2, 0);
    drive_sample(3, 1); drive_sample(4, 0); drive_sample(5, 0);
    chk("mid_post_trig_ptr", 32'(trig_ptr), 32'd3);
    chk("mid_post_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_trig_ptr", 32'(trig_ptr), 0);
    chk("async_rst_rd_vld", 32'(rd_vld), 0);
    chk("async_rst_rd_data", rd_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    read_addr(5, 32'h0);
    read_addr(6, 32'h0);
    drain();
    chk("idle_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
